load_store_unit: RTL and testbench

- Data-memory side of the writeback path: produces the `readData` word that the result mux selects for loads, and issues stores.
- Sits between the single-cycle datapath (`aluResult` as address, rs2 as store data, `funct3`) and a variable-latency data bus with a req/ack handshake.
- Stalls the core until each access completes.
- Handles byte/halfword lane steering, byte enables, load sign/zero extension, misalignment and timeout faults.

---
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit bridging the datapath to a req/ack data bus
// Stalls the core per access; steers byte lanes, extends loads, flags misalignment and bus timeouts.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        accessFault,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busBe,
  input  logic        busAck,
  input  logic [31:0] busRdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      stateNext;
  logic [2:0]  funct3Q;
  logic [1:0]  offQ;
  logic [15:0] waitCount;
  logic        timeoutQ;

  logic        bad;
  logic        start;
  logic        timeoutHit;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic [1:0]  off;

  assign off = aluResult[1:0];

  always_comb begin
    bad = 1'b0;
    case (funct3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = aluResult[0];
      3'b010:         bad = (aluResult[1:0] != 2'b00);
      default:        bad = 1'b1;
    endcase
  end

  assign start      = (memRead | memWrite) & ~bad;
  assign timeoutHit = (state == ACCESS) && !busAck && (waitCount == TIMEOUT_LAST);

  // Lane steering is computed from the live request and captured only on start.
  always_comb begin
    beNext    = 4'b0000;
    wdataNext = writeData;
    case (funct3[1:0])
      2'b00: begin
        beNext    = 4'b0001 << off;
        wdataNext = {4{writeData[7:0]}};
      end
      2'b01: begin
        beNext    = 4'b0011 << off;
        wdataNext = {2{writeData[15:0]}};
      end
      2'b10: begin
        beNext    = 4'b1111;
        wdataNext = writeData;
      end
      default: begin
        beNext    = 4'b0000;
        wdataNext = writeData;
      end
    endcase
  end

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] o,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (o)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = o[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'h0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'h0, h};
      default: extract = word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // DONE ignores memRead/memWrite: they still belong to the instruction being committed.
  always_comb begin
    stateNext   = state;
    stall       = 1'b0;
    accessFault = 1'b0;
    case (state)
      IDLE: begin
        stall       = start;
        accessFault = (memRead | memWrite) & bad;
        if (start) begin
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (busAck || timeoutHit) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        accessFault = timeoutQ;
        stateNext   = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readData  <= 32'h0;
      busReq    <= 1'b0;
      busWe     <= 1'b0;
      busAddr   <= 32'h0;
      busWdata  <= 32'h0;
      busBe     <= 4'b0000;
      funct3Q   <= 3'b000;
      offQ      <= 2'b00;
      waitCount <= 16'h0;
      timeoutQ  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busReq    <= 1'b1;
            busWe     <= memWrite;
            busAddr   <= {aluResult[31:2], 2'b00};
            busWdata  <= wdataNext;
            busBe     <= beNext;
            funct3Q   <= funct3;
            offQ      <= off;
            waitCount <= 16'h0;
            timeoutQ  <= 1'b0;
          end
        end
        ACCESS: begin
          if (busAck) begin
            busReq <= 1'b0;
            if (!busWe) begin
              readData <= extract(funct3Q, offQ, busRdata);
            end
          end else if (timeoutHit) begin
            busReq   <= 1'b0;
            timeoutQ <= 1'b1;
            if (!busWe) begin
              readData <= 32'h0;
            end
          end else begin
            waitCount <= waitCount + 16'h1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] aluResult;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        stall;
  logic        accessFault;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic        busAck;
  logic [31:0] busRdata;

  int passCount;
  int totalCount;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .aluResult(aluResult), .writeData(writeData),
    .readData(readData), .stall(stall), .accessFault(accessFault),
    .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busWdata(busWdata),
    .busBe(busBe), .busAck(busAck), .busRdata(busRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    totalCount++; if (readData !== 32'h0) $display("FAIL reset_readData got %h exp %h", readData, 32'h0); else passCount++;
    totalCount++; if (busReq !== 1'b0) $display("FAIL reset_busReq got %b exp 0", busReq); else passCount++;
    totalCount++; if (busAddr !== 32'h0 || busWdata !== 32'h0 || busBe !== 4'h0 || busWe !== 1'b0)
      $display("FAIL reset_bus got addr %h wdata %h be %b we %b exp all 0", busAddr, busWdata, busBe, busWe); else passCount++;
    totalCount++; if (stall !== 1'b0 || accessFault !== 1'b0)
      $display("FAIL reset_stall_fault got %b %b exp 0 0", stall, accessFault); else passCount++;
  endtask

  task automatic test_lw();
    int stallCycles;
    step();
    memRead = 1'b1; funct3 = 3'b010; aluResult = 32'h100; busAck = 1'b0;
    #1;
    stallCycles = stall ? 1 : 0;
    step();
    busAck = 1'b1; busRdata = 32'hDEADBEEF;
    #1;
    if (stall) stallCycles++;
    totalCount++; if (busReq !== 1'b1 || busAddr !== 32'h100 || busBe !== 4'b1111 || busWe !== 1'b0)
      $display("FAIL lw_bus got req %b addr %h be %b we %b exp 1 00000100 1111 0", busReq, busAddr, busBe, busWe); else passCount++;
    step();
    busAck = 1'b0;
    #1;
    if (stall) stallCycles++;
    totalCount++; if (readData !== 32'hDEADBEEF) $display("FAIL lw_readData got %h exp deadbeef", readData); else passCount++;
    totalCount++; if (stallCycles != 2) $display("FAIL lw_stallCycles got %0d exp 2", stallCycles); else passCount++;
    step();
    memRead = 1'b0;
  endtask

  task automatic test_byte_loads();
    memRead = 1'b1; funct3 = 3'b000; aluResult = 32'h103;
    step();
    busAck = 1'b1; busRdata = 32'h80FF1234;
    #1;
    totalCount++; if (busBe !== 4'b1000) $display("FAIL lb_busBe got %b exp 1000", busBe); else passCount++;
    step();
    busAck = 1'b0;
    #1;
    totalCount++; if (readData !== 32'hFFFFFF80) $display("FAIL lb_readData got %h exp ffffff80", readData); else passCount++;
    step();
    funct3 = 3'b100;
    step();
    busAck = 1'b1;
    #1;
    totalCount++; if (busBe !== 4'b1000) $display("FAIL lbu_busBe got %b exp 1000", busBe); else passCount++;
    step();
    busAck = 1'b0;
    #1;
    totalCount++; if (readData !== 32'h00000080) $display("FAIL lbu_readData got %h exp 00000080", readData); else passCount++;
    step();
    memRead = 1'b0;
  endtask

  task automatic test_store_half_wait();
    int stallCycles;
    int reqCycles;
    memWrite = 1'b1; funct3 = 3'b001; aluResult = 32'h202; writeData = 32'h0000ABCD;
    #1;
    stallCycles = stall ? 1 : 0;
    reqCycles = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      busAck = (i == 3);
      #1;
      if (stall) stallCycles++;
      if (busReq) reqCycles++;
      if (i == 0) begin
        totalCount++; if (busWdata !== 32'hABCDABCD || busBe !== 4'b1100 || busWe !== 1'b1)
          $display("FAIL sh_bus got wdata %h be %b we %b exp abcdabcd 1100 1", busWdata, busBe, busWe); else passCount++;
      end
    end
    step();
    busAck = 1'b0;
    #1;
    if (stall) stallCycles++;
    if (busReq) reqCycles++;
    totalCount++; if (reqCycles != 4) $display("FAIL sh_reqCycles got %0d exp 4", reqCycles); else passCount++;
    totalCount++; if (stallCycles != 5) $display("FAIL sh_stallCycles got %0d exp 5", stallCycles); else passCount++;
    totalCount++; if (readData !== 32'h00000080) $display("FAIL sh_readData got %h exp 00000080", readData); else passCount++;
    step();
    memWrite = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s [3];
    logic [31:0] addrs [3];
    f3s[0] = 3'b010; addrs[0] = 32'h101;
    f3s[1] = 3'b001; addrs[1] = 32'h003;
    f3s[2] = 3'b011; addrs[2] = 32'h000;
    for (int i = 0; i < 3; i++) begin
      memRead = 1'b1; funct3 = f3s[i]; aluResult = addrs[i];
      #1;
      totalCount++; if (accessFault !== 1'b1 || stall !== 1'b0)
        $display("FAIL bad_%0d_same_cycle got fault %b stall %b exp 1 0", i, accessFault, stall); else passCount++;
      step();
      #1;
      totalCount++; if (busReq !== 1'b0 || accessFault !== 1'b1)
        $display("FAIL bad_%0d_no_req got req %b fault %b exp 0 1", i, busReq, accessFault); else passCount++;
      step();
    end
    memRead = 1'b0;
    #1;
    totalCount++; if (accessFault !== 1'b0) $display("FAIL bad_cleared got %b exp 0", accessFault); else passCount++;
    step();
  endtask

  task automatic test_timeout();
    int reqCycles;
    logic sawDone;
    memRead = 1'b1; funct3 = 3'b010; aluResult = 32'h40; busRdata = 32'h12345678;
    reqCycles = 0;
    sawDone = 1'b0;
    for (int i = 0; i < 12 && !sawDone; i++) begin
      step();
      #1;
      if (busReq) reqCycles++;
      if (!stall) begin
        sawDone = 1'b1;
        totalCount++; if (accessFault !== 1'b1 || readData !== 32'h0)
          $display("FAIL timeout_done got fault %b data %h exp 1 00000000", accessFault, readData); else passCount++;
      end
    end
    totalCount++; if (!sawDone || reqCycles != 4)
      $display("FAIL timeout_reqCycles got %0d done %b exp 4 1", reqCycles, sawDone); else passCount++;
    step();
    memRead = 1'b0; busAck = 1'b1;
    step();
    busAck = 1'b0;
    #1;
    totalCount++; if (readData !== 32'h0 || busReq !== 1'b0 || stall !== 1'b0 || accessFault !== 1'b0)
      $display("FAIL timeout_late_ack got data %h req %b stall %b fault %b exp 0 0 0 0", readData, busReq, stall, accessFault); else passCount++;
  endtask

  task automatic test_reset_mid_access();
    memRead = 1'b1; funct3 = 3'b010; aluResult = 32'h10;
    step();
    busAck = 1'b1; busRdata = 32'h11223344;
    step();
    busAck = 1'b0;
    #1;
    totalCount++; if (readData !== 32'h11223344) $display("FAIL pre_reset_readData got %h exp 11223344", readData); else passCount++;
    step();
    aluResult = 32'h20;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; memRead = 1'b0; busAck = 1'b1;
    #1;
    totalCount++; if (busReq !== 1'b0 || stall !== 1'b0 || readData !== 32'h0)
      $display("FAIL mid_reset got req %b stall %b data %h exp 0 0 00000000", busReq, stall, readData); else passCount++;
    step();
    busAck = 1'b0;
    #1;
    totalCount++; if (busReq !== 1'b0 || readData !== 32'h0)
      $display("FAIL mid_reset_late_ack got req %b data %h exp 0 00000000", busReq, readData); else passCount++;
  endtask

  task automatic test_back_to_back_store_hold();
    int reqCycles;
    memRead = 1'b1; memWrite = 1'b1; funct3 = 3'b010; aluResult = 32'h300; writeData = 32'h12345678;
    step();
    busAck = 1'b1; busRdata = 32'hCAFEF00D;
    #1;
    totalCount++; if (busWe !== 1'b1 || busWdata !== 32'h12345678 || busBe !== 4'b1111 || busAddr !== 32'h300)
      $display("FAIL sw_bus got we %b wdata %h be %b addr %h exp 1 12345678 1111 00000300", busWe, busWdata, busBe, busAddr); else passCount++;
    reqCycles = 1;
    step();
    busAck = 1'b0;
    #1;
    if (busReq) reqCycles++;
    totalCount++; if (readData !== 32'h0) $display("FAIL sw_readData got %h exp 00000000", readData); else passCount++;
    step();
    memRead = 1'b0; memWrite = 1'b0;
    #1;
    if (busReq) reqCycles++;
    step();
    #1;
    if (busReq) reqCycles++;
    totalCount++; if (reqCycles != 1) $display("FAIL sw_single_write got %0d req cycles exp 1", reqCycles); else passCount++;
  endtask

  initial begin
    passCount = 0;
    totalCount = 0;
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b000;
    aluResult = 32'h0; writeData = 32'h0; busAck = 1'b0; busRdata = 32'h0;
    test_reset();
    test_lw();
    test_byte_loads();
    test_store_half_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back_store_hold();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
